// File: rtl/mfcc_pkg.sv
// Shared types and default widths for the MFCC mel-filterbank stage.
package mfcc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } mfcc_state_t;

  localparam int unsigned MFCC_NBINS_LOG2 = 9;
  localparam int unsigned MFCC_COEF_W     = 8;
  localparam int unsigned MFCC_PWR_W      = 32;

  // Wide enough to sum NBINS full-scale products without overflow.
  function automatic int unsigned mfcc_acc_width(input int unsigned pwr_w,
                                                 input int unsigned coef_w,
                                                 input int unsigned addr_w);
    return pwr_w + coef_w + addr_w;
  endfunction

endpackage

// File: rtl/mfcc_mac_pipe.sv
// Aligns power bins with their ROM weights, multiplies, accumulates and
// presents the truncated, saturated band energy.
module mfcc_mac_pipe
  import mfcc_pkg::*;
#(
  parameter int PWR_WIDTH   = MFCC_PWR_W,
  parameter int COEF_WIDTH  = MFCC_COEF_W,
  parameter int ADDR_WIDTH  = MFCC_NBINS_LOG2,
  parameter int OUT_WIDTH   = 32,
  parameter int ROM_LATENCY = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  beat_valid,
  input  logic [PWR_WIDTH-1:0]  beat_data,
  input  logic [COEF_WIDTH-1:0] coef,
  output logic [OUT_WIDTH-1:0]  res
);

  localparam int ACC_W  = int'(mfcc_acc_width(PWR_WIDTH, COEF_WIDTH, ADDR_WIDTH));
  localparam int PROD_W = PWR_WIDTH + COEF_WIDTH;
  localparam int RES_W  = ACC_W - COEF_WIDTH;
  localparam int EXT_W  = (RES_W > OUT_WIDTH) ? RES_W : OUT_WIDTH + 1;

  logic [PWR_WIDTH-1:0] pwr_dl [ROM_LATENCY];
  logic                 vld_dl [ROM_LATENCY];
  logic [PROD_W-1:0]    prod_q;
  logic                 prod_v;
  logic [ACC_W-1:0]     acc;
  logic [EXT_W-1:0]     res_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        pwr_dl[i] <= '0;
        vld_dl[i] <= 1'b0;
      end
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else if (clr) begin
      for (int unsigned i = 0; i < ROM_LATENCY; i++) begin
        pwr_dl[i] <= '0;
        vld_dl[i] <= 1'b0;
      end
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
    end else begin
      pwr_dl[0] <= beat_data;
      vld_dl[0] <= beat_valid;
      for (int unsigned i = 1; i < ROM_LATENCY; i++) begin
        pwr_dl[i] <= pwr_dl[i-1];
        vld_dl[i] <= vld_dl[i-1];
      end
      prod_q <= PROD_W'(pwr_dl[ROM_LATENCY-1]) * PROD_W'(coef);
      prod_v <= vld_dl[ROM_LATENCY-1];
      if (prod_v) acc <= acc + ACC_W'(prod_q);
    end
  end

  // Extended view of acc>>COEF_WIDTH so the overflow test works for any OUT_WIDTH.
  assign res_ext = EXT_W'(acc >> COEF_WIDTH);
  assign res     = (|(res_ext >> OUT_WIDTH)) ? '1 : res_ext[OUT_WIDTH-1:0];

endmodule

// File: rtl/mfcc_melbank_filter.sv
// Mel-band reader: streams one frame of power bins against the melbank ROM
// and emits one saturated band energy per frame.
module mfcc_melbank_filter
  import mfcc_pkg::*;
#(
  parameter int ADDR_WIDTH  = MFCC_NBINS_LOG2,
  parameter int COEF_WIDTH  = MFCC_COEF_W,
  parameter int PWR_WIDTH   = MFCC_PWR_W,
  parameter int OUT_WIDTH   = 32,
  parameter int ROM_LATENCY = 1
)(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PWR_WIDTH-1:0]  s_data,
  input  logic                  s_last,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [COEF_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [OUT_WIDTH-1:0]  m_data,
  output logic                  m_err,
  output logic                  busy
);

  localparam logic [1:0] DRAIN_LAST = 2'(ROM_LATENCY + 1);

  mfcc_state_t           state_q, state_d;
  logic [ADDR_WIDTH-1:0] bin_cnt;
  logic [1:0]            drain_cnt;
  logic                  err_pend;
  logic                  accept, last_bin, close, clr;

  assign accept   = s_valid && (state_q == ST_ACCUM);
  assign last_bin = (bin_cnt == '1);
  assign close    = accept && (s_last || last_bin);
  assign rom_addr = bin_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE:  state_d = ST_ACCUM;
      ST_ACCUM: begin
        s_ready = 1'b1;
        if (s_valid && (s_last || last_bin)) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (drain_cnt == DRAIN_LAST) state_d = ST_HOLD;
      ST_HOLD: begin
        m_valid = 1'b1;
        if (m_ready) begin
          clr     = 1'b1;
          state_d = ST_ACCUM;
        end
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_cnt   <= '0;
      drain_cnt <= '0;
      err_pend  <= 1'b0;
    end else begin
      if (close)       bin_cnt <= '0;
      else if (accept) bin_cnt <= bin_cnt + 1'b1;

      if (state_q == ST_DRAIN) drain_cnt <= drain_cnt + 1'b1;
      else                     drain_cnt <= '0;

      // Short frame (early s_last) and long frame (no s_last at the end) both flag.
      if (close)                err_pend <= s_last ^ last_bin;
      else if (m_valid && m_ready) err_pend <= 1'b0;
    end
  end

  assign m_err = m_valid && err_pend;
  assign busy  = ((state_q == ST_ACCUM) && (bin_cnt != '0)) ||
                 (state_q == ST_DRAIN) || (state_q == ST_HOLD);

  mfcc_mac_pipe #(
    .PWR_WIDTH   (PWR_WIDTH),
    .COEF_WIDTH  (COEF_WIDTH),
    .ADDR_WIDTH  (ADDR_WIDTH),
    .OUT_WIDTH   (OUT_WIDTH),
    .ROM_LATENCY (ROM_LATENCY)
  ) u_mac (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr),
    .beat_valid (accept),
    .beat_data  (s_data),
    .coef       (rom_rd_data),
    .res        (m_data)
  );

endmodule

// File: tb/tb_mfcc_melbank_filter.sv
// Bench for mfcc_melbank_filter: three instances (32-bit/L1, 48-bit/L1,
// 32-bit/L2) share one stimulus stream and are checked against a frame model.
module tb_mfcc_melbank_filter;

  logic        clk_tb = 1'b0;
  logic        tb_rst;
  logic        s_valid, s_last, m_ready;
  logic [31:0] s_data;
  logic [2:0]  sr, mv, me, busy_w;
  logic [8:0]  ra0, ra1, ra2;
  logic [7:0]  rd0, rd1, rd2, rd2_p;
  logic [31:0] md0, md2;
  logic [47:0] md1;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned cyc = 0;

  always #5 clk_tb = ~clk_tb;
  always @(posedge clk_tb) cyc <= cyc + 1;

  mfcc_melbank_filter #(.OUT_WIDTH(32), .ROM_LATENCY(1)) dut0 (
    .clk(clk_tb), .rst_n(tb_rst), .s_valid(s_valid), .s_ready(sr[0]), .s_data(s_data),
    .s_last(s_last), .rom_addr(ra0), .rom_rd_data(rd0), .m_valid(mv[0]), .m_ready(m_ready),
    .m_data(md0), .m_err(me[0]), .busy(busy_w[0]));

  mfcc_melbank_filter #(.OUT_WIDTH(48), .ROM_LATENCY(1)) dut1 (
    .clk(clk_tb), .rst_n(tb_rst), .s_valid(s_valid), .s_ready(sr[1]), .s_data(s_data),
    .s_last(s_last), .rom_addr(ra1), .rom_rd_data(rd1), .m_valid(mv[1]), .m_ready(m_ready),
    .m_data(md1), .m_err(me[1]), .busy(busy_w[1]));

  mfcc_melbank_filter #(.OUT_WIDTH(32), .ROM_LATENCY(2)) dut2 (
    .clk(clk_tb), .rst_n(tb_rst), .s_valid(s_valid), .s_ready(sr[2]), .s_data(s_data),
    .s_last(s_last), .rom_addr(ra2), .rom_rd_data(rd2), .m_valid(mv[2]), .m_ready(m_ready),
    .m_data(md2), .m_err(me[2]), .busy(busy_w[2]));

  // ROM images: w[k] = k[7:0]
  always @(posedge clk_tb) begin
    rd0   <= ra0[7:0];
    rd1   <= ra1[7:0];
    rd2_p <= ra2[7:0];
    rd2   <= rd2_p;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sat(input logic [63:0] v, input int unsigned w);
    if ((v >> w) != 64'd0) return (64'd1 << w) - 64'd1;
    return v;
  endfunction

  function automatic logic [63:0] md_of(input int i);
    case (i)
      0:       return 64'(md0);
      1:       return 64'(md1);
      default: return 64'(md2);
    endcase
  endfunction

  // Frame model: sum of bin*weight over the accepted beats of each frame
  typedef struct {
    logic [63:0] data;
    logic        err;
    int unsigned close_cyc;
  } exp_t;

  exp_t              eq [3][$];
  longint unsigned   m_sum = 0;
  int unsigned       m_idx = 0;
  logic [63:0]       mdl_last = '0;
  logic              mdl_last_err = 1'b0;
  logic [63:0]       last_data [3];
  logic              last_err [3];
  logic [2:0]        mv_prev = '0;

  always @(posedge clk_tb) begin
    if (!tb_rst) begin
      m_sum = 0;
      m_idx = 0;
      for (int i = 0; i < 3; i++) eq[i].delete();
    end else if (s_valid && (&sr)) begin
      m_sum += 64'(s_data) * 64'(m_idx % 256);
      if (s_last || m_idx == 511) begin
        exp_t e;
        logic [63:0] r;
        r            = m_sum >> 8;
        e.err        = s_last ^ (m_idx == 511);
        e.close_cyc  = cyc + 1;
        e.data       = sat(r, 32);
        eq[0].push_back(e);
        eq[2].push_back(e);
        e.data       = sat(r, 48);
        eq[1].push_back(e);
        mdl_last     = sat(r, 32);
        mdl_last_err = e.err;
        m_sum = 0;
        m_idx = 0;
      end else begin
        m_idx++;
      end
    end
  end

  always @(posedge clk_tb) begin
    if (tb_rst)
      for (int i = 0; i < 3; i++)
        if (mv[i] && m_ready && eq[i].size() > 0) void'(eq[i].pop_front());
  end

  always @(negedge clk_tb) begin
    if (!tb_rst) begin
      mv_prev = '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (mv[i]) begin
          if (eq[i].size() == 0) begin
            chk("unexpected_m_valid", 64'(mv[i]), 64'd0);
          end else begin
            if (!mv_prev[i])
              chk("latency", 64'(cyc - eq[i][0].close_cyc), (i == 2) ? 64'd4 : 64'd3);
            chk("m_data", md_of(i), eq[i][0].data);
            chk("m_err", 64'(me[i]), 64'(eq[i][0].err));
            chk("s_ready_in_hold", 64'(sr[i]), 64'd0);
          end
          last_data[i] = md_of(i);
          last_err[i]  = me[i];
        end
      end
      mv_prev = mv;
    end
  end

  task automatic idle(input int unsigned n);
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (n) @(negedge clk_tb);
  endtask

  task automatic beat(input logic [31:0] d, input logic l);
    int unsigned t = 0;
    while (!(&sr)) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      t++;
      if (t > 200) begin
        chk("beat_wait_timeout", 64'(sr), 64'd7);
        return;
      end
      @(negedge clk_tb);
    end
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    @(negedge clk_tb);
  endtask

  task automatic wait_done();
    int unsigned t = 0;
    idle(1);
    while (!((eq[0].size() == 0) && (eq[1].size() == 0) && (eq[2].size() == 0) && (&sr))) begin
      t++;
      if (t > 200) begin
        chk("result_wait_timeout", 64'(eq[0].size()), 64'd0);
        return;
      end
      @(negedge clk_tb);
    end
  endtask

  task automatic ones_frame(input logic [31:0] v);
    for (int i = 0; i < 512; i++) beat(v, i == 511);
  endtask

  task automatic reset_checks();
    chk("rst_s_ready", 64'(sr), 64'd0);
    chk("rst_m_valid", 64'(mv), 64'd0);
    chk("rst_m_err", 64'(me), 64'd0);
    chk("rst_busy", 64'(busy_w), 64'd0);
    chk("rst_rom_addr", 64'({ra0, ra1, ra2}), 64'd0);
    chk("rst_m_data", md_of(0) | md_of(1) | md_of(2), 64'd0);
  endtask

  initial begin
    tb_rst  = 1'b0;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk_tb);
    reset_checks();
    tb_rst = 1'b1;
    @(negedge clk_tb);
    @(negedge clk_tb);
    chk("accum_after_reset", 64'(sr), 64'd7);

    // 1: all ones, full frame
    ones_frame(32'd1);
    wait_done();
    chk("t1_model", mdl_last, 64'd255);
    chk("t1_data", last_data[0], 64'd255);
    chk("t1_err", 64'(last_err[0]), 64'd0);
    chk("t1_data_lat2", last_data[2], 64'd255);

    // 2: single weighted bin with random gaps
    for (int i = 0; i < 512; i++) begin
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      beat((i == 3) ? 32'd256 : 32'd0, i == 511);
    end
    wait_done();
    chk("t2_model", mdl_last, 64'd3);
    chk("t2_data", last_data[0], 64'd3);
    chk("t2_err", 64'(last_err[0]), 64'd0);

    // 3: short frame then clean full frame
    for (int i = 0; i < 100; i++) beat(32'd256, i == 99);
    wait_done();
    chk("t3_model", mdl_last, 64'd4950);
    chk("t3_data", last_data[0], 64'd4950);
    chk("t3_err", 64'(last_err[0]), 64'd1);
    ones_frame(32'd1);
    wait_done();
    chk("t3b_data", last_data[0], 64'd255);
    chk("t3b_err", 64'(last_err[0]), 64'd0);

    // 4: backpressure on the result
    m_ready = 1'b0;
    ones_frame(32'd1);
    idle(1);
    for (int t = 0; t < 50 && !(&mv); t++) @(negedge clk_tb);
    chk("t4_all_valid", 64'(mv), 64'd7);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk_tb);
      chk("t4_hold_data", 64'(md0), 64'd255);
      chk("t4_hold_err", 64'(me[0]), 64'd0);
      chk("t4_hold_valid", 64'(mv), 64'd7);
      chk("t4_hold_busy", 64'(busy_w[0]), 64'd1);
    end
    m_ready = 1'b1;
    @(negedge clk_tb);
    chk("t4_valid_drop", 64'(mv), 64'd0);
    chk("t4_ready_back", 64'(sr), 64'd7);
    chk("t4_busy_clear", 64'(busy_w), 64'd0);
    wait_done();

    // 5: saturation at 32 bits, exact at 48 bits
    ones_frame(32'hFFFF_FFFF);
    wait_done();
    chk("t5_model", mdl_last, 64'hFFFF_FFFF);
    chk("t5_sat32", last_data[0], 64'hFFFF_FFFF);
    chk("t5_exact48", last_data[1], 64'h00FE_FFFF_FF01);

    // Long frame: closes at bin 511, spill beats form a short frame
    for (int i = 0; i < 514; i++) beat(32'd1, i == 513);
    wait_done();
    chk("long_tail_data", last_data[0], 64'd0);
    chk("long_tail_err", 64'(last_err[0]), 64'd1);

    // 6: reset mid-frame
    for (int i = 0; i < 50; i++) beat(32'd1, 1'b0);
    idle(1);
    chk("t6_busy_mid", 64'(busy_w), 64'd7);
    tb_rst = 1'b0;
    @(negedge clk_tb);
    reset_checks();
    @(negedge clk_tb);
    tb_rst = 1'b1;
    @(negedge clk_tb);
    ones_frame(32'd1);
    wait_done();
    chk("t6_data", last_data[0], 64'd255);
    chk("t6_err", 64'(last_err[0]), 64'd0);
    chk("t6_model_err", 64'(mdl_last_err), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    vectors++;
    miscompares++;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
